// File: rtl/serial_link_master.sv
// serial_link_master: frames one CPU request per 6-phase cycle onto in_bits and rebuilds a 21-bit response from out_bits.
// Ports: clk/reset (sync, active-high); req_* request frame accepted while phase==5;
// mem_ctl latched every frame; in_bits/out_bits serial streams; phase/frame_start show position in the frame;
// rsp_* response FIFO head; rsp_overflow/drop_count report dropped pushes; frame_count counts completed frames.
module serial_link_master #(
    parameter int RSP_DEPTH  = 4,
    parameter int DROP_CNT_W = 8,
    parameter int RSP_FILTER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_cpu_valid,
    input  logic [3:0]            req_cpu_cmd,
    input  logic [3:0]            req_cpu_wdata,
    input  logic [23:0]           req_cpu_addr,
    input  logic [2:0]            mem_ctl,
    output logic [11:0]           in_bits,
    input  logic [11:0]           out_bits,
    output logic [2:0]            phase,
    output logic                  frame_start,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [20:0]           rsp_word,
    output logic                  rsp_overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [15:0]           frame_count
);
    localparam int AW = $clog2(RSP_DEPTH);
    logic [3:0]  fr_valid, fr_cmd, fr_wdata;
    logic [23:0] fr_addr;
    logic [2:0]  mem_ctl_q;
    logic [11:0] lo;
    logic [20:0] word;
    logic [20:0] mem [RSP_DEPTH];
    logic [AW:0] wp, rp;
    logic        accept, keep, push, full, empty, rd, wr, drop;
    assign req_ready   = (phase == 3'd5) && !reset;
    assign accept      = req_valid && req_ready;
    assign frame_start = phase == 3'd0;
    // out_bits[11:9] of the second response beat carry nothing
    assign word  = {out_bits[8:0], lo};
    // filter keeps words with any cpu_read_valid bit or mem_req_valid set
    assign keep  = (RSP_FILTER == 0) || (|word[16:13]) || word[8];
    assign push  = (phase == 3'd5) && keep;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd    = rsp_ready && !empty;
    assign wr    = push && (!full || rd);
    assign drop  = push && full && !rd;
    assign rsp_valid = !empty;
    assign rsp_word  = mem[rp[AW-1:0]];
    always_comb begin
        in_bits = (phase == 3'd0) ? {fr_valid, fr_cmd, fr_wdata} :
                  (phase == 3'd1) ? fr_addr[11:0] :
                  (phase == 3'd2) ? fr_addr[23:12] :
                  (phase == 3'd3) ? {9'b0, mem_ctl_q} : 12'h000;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= 3'd0;
            fr_valid     <= '0;
            fr_cmd       <= '0;
            fr_wdata     <= '0;
            fr_addr      <= '0;
            mem_ctl_q    <= '0;
            lo           <= '0;
            wp           <= '0;
            rp           <= '0;
            rsp_overflow <= 1'b0;
            drop_count   <= '0;
            frame_count  <= '0;
        end else begin
            phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd4)
                lo <= out_bits;
            if (phase == 3'd5) begin
                fr_valid    <= accept ? req_cpu_valid : 4'h0;
                fr_cmd      <= accept ? req_cpu_cmd   : 4'h0;
                fr_wdata    <= accept ? req_cpu_wdata : 4'h0;
                fr_addr     <= accept ? req_cpu_addr  : 24'h0;
                mem_ctl_q   <= mem_ctl;
                frame_count <= frame_count + 16'd1;
            end
            if (wr)
                wp <= wp + (AW+1)'(1);
            if (rd)
                rp <= rp + (AW+1)'(1);
            if (drop) begin
                rsp_overflow <= 1'b1;
                drop_count   <= (&drop_count) ? drop_count : drop_count + DROP_CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr)
            mem[wp[AW-1:0]] <= word;
    end
endmodule
